mac_accum_seq: RTL and testbench
================================

// Module: mac_accum_seq
// PURPOSE
//   Parametrised sequential multiply-accumulate engine; next generation of the 16-bit combinational MAC.
//   Iterative shift-add multiply, one partial product per clock.
//   Result is added to in_c or to an internal accumulator; signed/unsigned modes; optional saturation.
//   valid/ready handshakes on both sides; sits between an operand FIFO and a result FIFO in the datapath.
// PARAMETERS
//   DATA_W  16  operand width (in_a, in_b, in_c); legal >= 2
//   ACC_W   40  accumulator/result width; must be >= 2*DATA_W
//   SAT      1  1: clamp on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//   clk       in   1       clock, rising edge
//   rst       in   1       reset, asynchronous, active-high
//   in_valid  in   1       operand set valid
//   in_ready  out  1       engine can accept operands (IDLE only)
//   in_a      in   DATA_W  multiplicand
//   in_b      in   DATA_W  multiplier
//   in_c      in   DATA_W  addend (used when op_acc=0)
//   op_signed in   1       1: two's-complement operands/result; 0: unsigned
//   op_acc    in   1       1: result = acc + a*b, stored back to acc; 0: result = a*b + ext(in_c)
//   acc_clr   in   1       zero the accumulator (see rules)
//   out_valid out  1       mac_out/out_ovf valid
//   out_ready in   1       consumer accepts result
//   mac_out   out  ACC_W   result
//   out_ovf   out  1       result overflowed ACC_W (clamped if SAT=1)
// BEHAVIOUR
//   Reset: state=IDLE, acc=0, mac_out=0, out_ovf=0, out_valid=0, in_ready=1 (combinational from IDLE).
//     Reset mid-operation aborts; no result emitted.
//   FSM: IDLE -> MUL -> ADD -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, c, op_signed, op_acc; go MUL.
//   MUL: DATA_W cycles.
//     Signed mode multiplies magnitudes and negates the 2*DATA_W product if sign(a)^sign(b).
//     Operands are latched; input port changes during MUL have no effect.
//   ADD: 1 cycle.
//     Product extended to ACC_W (sign-extended if op_signed, else zero-extended).
//     Addend: acc when op_acc=1; otherwise in_c extended the same way.
//     Sum computed in ACC_W+1 bits.
//     Overflow: unsigned = carry out of ACC_W; signed = sum outside signed ACC_W range.
//     SAT=1 and overflow: result = max (unsigned all-ones; signed 0x7F..F) or signed min (0x80..0).
//     SAT=0: result wraps; out_ovf still set.
//     mac_out and out_ovf registered; acc <= result when op_acc=1.
//   DONE: out_valid=1; mac_out/out_ovf held stable until out_valid&&out_ready; then IDLE.
//   Latency: out_valid rises DATA_W+2 clocks after the accept edge.
//   Throughput: one op per DATA_W+3 clocks with out_ready=1.
//   acc_clr: sampled in IDLE only; ignored in other states.
//     In IDLE without accept: acc <= 0 next edge.
//     Coincident with an accept: acc is treated as 0 for that op (clear before accumulate).
//   mac_out keeps its last value after the handshake until the next ADD.
//   out_ovf is per-op; it is not sticky.
//   op_acc=0 never modifies acc.
// TESTING (DATA_W=16, ACC_W=40, SAT=1 unless stated)
//   1. Unsigned basic: a=3, b=5, c=7, op_acc=0
//      -> mac_out=22, out_ovf=0, out_valid exactly 18 clocks after accept.
//   2. Signed: a=0xFFFD(-3), b=4, c=0xFFFE(-2), op_signed=1
//      -> mac_out=0xFF_FFFF_FFF2 (-14), out_ovf=0.
//   3. Accumulate, unsigned: 4 ops of a=b=0xFFFF, op_acc=1, acc_clr=1 on the first
//      -> final mac_out=0x3_FFF8_0004; then an op_acc=0 op leaves acc unchanged.
//   4. Saturation, ACC_W=32, unsigned: 2 accumulates of a=b=0xFFFF
//      -> 2nd mac_out=0xFFFF_FFFF, out_ovf=1.
//      Same run with SAT=0 -> 0xFFFC_0002, out_ovf=1.
//   5. Backpressure: hold out_ready=0 for 5 clocks in DONE with in_valid=1
//      -> mac_out stable, in_ready=0, no second accept; accept resumes 1 clock after the result handshake.
//   6. Reset mid-MUL (cycle 8): assert rst
//      -> out_valid=0, mac_out=0, acc=0, in_ready=1; next op a=2, b=2, c=0 returns 4.

Source files
------------

// File: rtl/mac_accum_seq.sv
// Sequential multiply-accumulate engine: shift-add multiply (one partial product per clock),
// then a single add against in_c or the internal accumulator, with optional saturation.
module mac_accum_seq #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ACC_W  = 40,
   parameter bit          SAT    = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_c,
   input  logic              op_signed,
   input  logic              op_acc,
   input  logic              acc_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  mac_out,
   output logic              out_ovf
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = $clog2(DATA_W);

   typedef enum logic [1:0] {StIdle, StMul, StAdd, StDone} state_e;

   state_e             state_q;
   logic [PROD_W-1:0]  mcand_q, prod_q;
   logic [DATA_W-1:0]  mult_q, c_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               sgn_q, acc_op_q, neg_q;
   logic [ACC_W-1:0]   acc_q, mac_out_q;
   logic               out_ovf_q, out_valid_q;

   logic [DATA_W-1:0]  mag_a, mag_b;
   logic [PROD_W-1:0]  prod_fin;
   logic [ACC_W-1:0]   prod_ext, c_ext, addend, sat_val, result;
   logic [ACC_W:0]     op_x, ad_x, sum;
   logic               ovf;

   // Signed mode multiplies magnitudes; the sign is reapplied to the full product.
   always_comb begin
      mag_a = (op_signed && in_a[DATA_W-1]) ? -in_a : in_a;
      mag_b = (op_signed && in_b[DATA_W-1]) ? -in_b : in_b;
   end

   always_comb begin
      prod_fin = neg_q ? -prod_q : prod_q;
      if (sgn_q) begin
         prod_ext = ACC_W'($signed(prod_fin));
         c_ext    = ACC_W'($signed(c_q));
      end else begin
         prod_ext = ACC_W'(prod_fin);
         c_ext    = ACC_W'(c_q);
      end
      addend = acc_op_q ? acc_q : c_ext;
      if (sgn_q) begin
         op_x = {prod_ext[ACC_W-1], prod_ext};
         ad_x = {addend[ACC_W-1], addend};
      end else begin
         op_x = {1'b0, prod_ext};
         ad_x = {1'b0, addend};
      end
      sum = op_x + ad_x;
      ovf = sgn_q ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
      // Signed overflow direction is given by the true sign bit of the wide sum.
      if (!sgn_q)         sat_val = {ACC_W{1'b1}};
      else if (sum[ACC_W]) sat_val = {1'b1, {(ACC_W-1){1'b0}}};
      else                sat_val = {1'b0, {(ACC_W-1){1'b1}}};
      result = (SAT && ovf) ? sat_val : sum[ACC_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         mcand_q     <= '0;
         prod_q      <= '0;
         mult_q      <= '0;
         c_q         <= '0;
         cnt_q       <= '0;
         sgn_q       <= 1'b0;
         acc_op_q    <= 1'b0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         mac_out_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // A clear coincident with an accept zeroes acc before the op uses it.
               if (acc_clr) acc_q <= '0;
               if (in_valid) begin
                  mcand_q  <= PROD_W'(mag_a);
                  mult_q   <= mag_b;
                  prod_q   <= '0;
                  cnt_q    <= '0;
                  c_q      <= in_c;
                  sgn_q    <= op_signed;
                  acc_op_q <= op_acc;
                  neg_q    <= op_signed & (in_a[DATA_W-1] ^ in_b[DATA_W-1]);
                  state_q  <= StMul;
               end
            end
            StMul: begin
               if (mult_q[0]) prod_q <= prod_q + mcand_q;
               mcand_q <= mcand_q << 1;
               mult_q  <= mult_q >> 1;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= StAdd;
            end
            StAdd: begin
               mac_out_q   <= result;
               out_ovf_q   <= ovf;
               if (acc_op_q) acc_q <= result;
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign mac_out   = mac_out_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Directed bench for mac_accum_seq: one 40-bit saturating instance plus 32-bit saturating and
// wrapping instances sharing the same stimulus.
`timescale 1ns/1ps
module tb_mac_accum_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic [15:0] in_a = '0, in_b = '0, in_c = '0;
   logic        op_signed = 1'b0, op_acc = 1'b0, acc_clr = 1'b0;

   logic        in_ready, out_valid, out_ovf;
   logic [39:0] mac_out;
   logic        in_ready_s, out_valid_s, out_ovf_s;
   logic [31:0] mac_out_s;
   logic        in_ready_w, out_valid_w, out_ovf_w;
   logic [31:0] mac_out_w;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mac_accum_seq #(.DATA_W(16), .ACC_W(40), .SAT(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_c(in_c), .op_signed(op_signed), .op_acc(op_acc), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .mac_out(mac_out), .out_ovf(out_ovf));

   mac_accum_seq #(.DATA_W(16), .ACC_W(32), .SAT(1'b1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_a(in_a),
      .in_b(in_b), .in_c(in_c), .op_signed(op_signed), .op_acc(op_acc), .acc_clr(acc_clr),
      .out_valid(out_valid_s), .out_ready(out_ready), .mac_out(mac_out_s), .out_ovf(out_ovf_s));

   mac_accum_seq #(.DATA_W(16), .ACC_W(32), .SAT(1'b0)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_a(in_a),
      .in_b(in_b), .in_c(in_c), .op_signed(op_signed), .op_acc(op_acc), .acc_clr(acc_clr),
      .out_valid(out_valid_w), .out_ready(out_ready), .mac_out(mac_out_w), .out_ovf(out_ovf_w));

   // Drives one op, scrambles the ports during MUL, returns results; lat counts the accept
   // clock as clock 1.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic sgn, input logic acc, input logic clr, output int lat,
                         output logic [39:0] res, output logic ovf, output logic [31:0] res_s,
                         output logic ovf_s, output logic [31:0] res_w, output logic ovf_w);
      int guard = 0;
      @(negedge clk);
      in_a = a; in_b = b; in_c = c; op_signed = sgn; op_acc = acc; acc_clr = clr;
      in_valid = 1'b1;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = ~a; in_b = ~b; in_c = ~c; op_signed = ~sgn; op_acc = ~acc; acc_clr = 1'b1;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      acc_clr = 1'b0;
      res = mac_out; ovf = out_ovf;
      res_s = mac_out_s; ovf_s = out_ovf_s;
      res_w = mac_out_w; ovf_w = out_ovf_w;
      @(posedge clk);
      #1;
   endtask

   int          lat;
   logic [39:0] r;
   logic [31:0] rs, rw;
   logic        o, os, ow;

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (mac_out !== 40'h0) begin fails++; $display("FAIL reset_mac_out got %h exp 0", mac_out); end
      tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unsigned_basic();
      run_op(16'd3, 16'd5, 16'd7, 1'b0, 1'b0, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (r !== 40'd22) begin fails++; $display("FAIL basic_result got %0d exp 22", r); end
      tests++; if (o !== 1'b0) begin fails++; $display("FAIL basic_ovf got %b exp 0", o); end
      tests++; if (lat != 18) begin fails++; $display("FAIL basic_latency got %0d exp 18", lat); end
   endtask

   task automatic test_signed();
      run_op(16'hFFFD, 16'd4, 16'hFFFE, 1'b1, 1'b0, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (r !== 40'hFF_FFFF_FFF2) begin fails++; $display("FAIL signed_result got %h exp fffffffff2", r); end
      tests++; if (o !== 1'b0) begin fails++; $display("FAIL signed_ovf got %b exp 0", o); end
      run_op(16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (r !== 40'h00_4000_0000) begin fails++; $display("FAIL signed_minsq got %h exp 0040000000", r); end
   endtask

   task automatic test_accumulate();
      logic [39:0] exp_acc [4] = '{40'h0_FFFE_0001, 40'h1_FFFC_0002, 40'h2_FFFA_0003,
                                   40'h3_FFF8_0004};
      for (int i = 0; i < 4; i++) begin
         run_op(16'hFFFF, 16'hFFFF, 16'h1234, 1'b0, 1'b1, (i == 0), lat, r, o, rs, os, rw, ow);
         tests++; if (r !== exp_acc[i]) begin fails++; $display("FAIL acc_step%0d got %h exp %h", i, r, exp_acc[i]); end
      end
      run_op(16'd1, 16'd1, 16'd5, 1'b0, 1'b0, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (r !== 40'd6) begin fails++; $display("FAIL acc_side_op got %0d exp 6", r); end
      run_op(16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (r !== 40'h3_FFF8_0004) begin fails++; $display("FAIL acc_preserved got %h exp 3fff80004", r); end
   endtask

   task automatic test_saturation();
      run_op(16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b1, 1'b1, lat, r, o, rs, os, rw, ow);
      tests++; if (rs !== 32'hFFFE_0001 || os !== 1'b0) begin fails++; $display("FAIL usat_first got %h/%b exp fffe0001/0", rs, os); end
      run_op(16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b1, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (rs !== 32'hFFFF_FFFF || os !== 1'b1) begin fails++; $display("FAIL usat_clamp got %h/%b exp ffffffff/1", rs, os); end
      tests++; if (rw !== 32'hFFFC_0002 || ow !== 1'b1) begin fails++; $display("FAIL uwrap got %h/%b exp fffc0002/1", rw, ow); end
      run_op(16'd1, 16'd1, 16'd0, 1'b0, 1'b0, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (rs !== 32'd1 || os !== 1'b0) begin fails++; $display("FAIL ovf_not_sticky got %h/%b exp 1/0", rs, os); end
      run_op(16'h8000, 16'h8000, 16'h0, 1'b1, 1'b1, 1'b1, lat, r, o, rs, os, rw, ow);
      run_op(16'h8000, 16'h8000, 16'h0, 1'b1, 1'b1, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (rs !== 32'h7FFF_FFFF || os !== 1'b1) begin fails++; $display("FAIL ssat_max got %h/%b exp 7fffffff/1", rs, os); end
      tests++; if (rw !== 32'h8000_0000 || ow !== 1'b1) begin fails++; $display("FAIL swrap_max got %h/%b exp 80000000/1", rw, ow); end
      run_op(16'h8000, 16'h7FFF, 16'h0, 1'b1, 1'b1, 1'b1, lat, r, o, rs, os, rw, ow);
      tests++; if (rs !== 32'hC000_8000) begin fails++; $display("FAIL sneg_first got %h exp c0008000", rs); end
      run_op(16'h8000, 16'h7FFF, 16'h0, 1'b1, 1'b1, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (rs !== 32'h8001_0000 || os !== 1'b0) begin fails++; $display("FAIL sneg_second got %h/%b exp 80010000/0", rs, os); end
      run_op(16'h8000, 16'h7FFF, 16'h0, 1'b1, 1'b1, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (rs !== 32'h8000_0000 || os !== 1'b1) begin fails++; $display("FAIL ssat_min got %h/%b exp 80000000/1", rs, os); end
      tests++; if (rw !== 32'h4001_8000 || ow !== 1'b1) begin fails++; $display("FAIL swrap_min got %h/%b exp 40018000/1", rw, ow); end
   endtask

   task automatic test_back_to_back();
      int guard = 0;
      @(negedge clk);
      out_ready = 1'b0;
      in_a = 16'd10; in_b = 16'd10; in_c = 16'd1; op_signed = 1'b0; op_acc = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      while (!out_valid && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      tests++; if (mac_out !== 40'd101) begin fails++; $display("FAIL bp_result got %0d exp 101", mac_out); end
      in_a = 16'd2; in_b = 16'd3; in_c = 16'd0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if (mac_out !== 40'd101 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d got out=%0d v=%b rdy=%b exp 101/1/0", i, mac_out, out_valid,
                     in_ready);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || mac_out !== 40'd101) begin
         fails++;
         $display("FAIL bp_release got v=%b rdy=%b out=%0d exp 0/1/101", out_valid, in_ready, mac_out);
      end
      @(posedge clk);
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_reaccept got rdy=%b exp 0", in_ready); end
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      tests++; if (mac_out !== 40'd6) begin fails++; $display("FAIL bp_second got %0d exp 6", mac_out); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      in_a = 16'h1234; in_b = 16'h5678; in_c = 16'h0; op_signed = 1'b0; op_acc = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || mac_out !== 40'h0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL midrst_state got v=%b out=%h rdy=%b exp 0/0/1", out_valid, mac_out, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(16'd2, 16'd2, 16'd0, 1'b0, 1'b0, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (r !== 40'd4 || lat != 18) begin fails++; $display("FAIL midrst_next got %0d lat %0d exp 4 lat 18", r, lat); end
      run_op(16'd1, 16'd1, 16'd0, 1'b0, 1'b1, 1'b0, lat, r, o, rs, os, rw, ow);
      tests++; if (r !== 40'd1) begin fails++; $display("FAIL midrst_acc_zero got %h exp 1", r); end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_accumulate();
      test_saturation();
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
